// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shifter with valid/ready on both sides, MSB- or LSB-first.
// Optional trailing parity bit when PISO_PARITY_EN is defined (sense set by PARITY_ODD).
module piso_serializer #(
    parameter int DATA_W     = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] par_data,
    input  logic              par_valid,
    output logic              par_ready,
    output logic              ser_data,
    output logic              ser_valid,
    input  logic              ser_ready,
    output logic              ser_last,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);

    function automatic logic parity_f(input logic [DATA_W-1:0] word);
        return (^word) ^ PARITY_ODD;
    endfunction

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_PAR = 2'd2} state_t;
    logic par_q, par_d;
`else
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1} state_t;
`endif

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  shreg_q, shreg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               load_s, xfer_s, last_s;
    logic [DATA_W-1:0]  shifted_s;

    // Output decode; everything except par_ready comes straight from registers
    always_comb begin
        ser_valid = (state_q != ST_IDLE);
        busy      = (state_q != ST_IDLE);
        ser_data  = MSB_FIRST ? shreg_q[DATA_W-1] : shreg_q[0];
`ifdef PISO_PARITY_EN
        last_s    = (state_q == ST_PAR);
        if (state_q == ST_PAR) begin
            ser_data = par_q;
        end else begin
            ser_data = MSB_FIRST ? shreg_q[DATA_W-1] : shreg_q[0];
        end
`else
        last_s    = (state_q == ST_SHIFT) && (cnt_q == LAST_IDX);
`endif
        ser_last  = last_s;
        xfer_s    = ser_valid & ser_ready;
        // Early ready on the final transfer lets the next word load with no bubble
        par_ready = (state_q == ST_IDLE) | (xfer_s & last_s);
        load_s    = par_valid & par_ready;
        shifted_s = MSB_FIRST ? {shreg_q[DATA_W-2:0], 1'b0} : {1'b0, shreg_q[DATA_W-1:1]};
    end

    // Next-state, shift register and bit counter
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
`ifdef PISO_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (load_s) begin
                    state_d = ST_SHIFT;
                    shreg_d = par_data;
                    cnt_d   = {CNT_W{1'b0}};
`ifdef PISO_PARITY_EN
                    par_d   = parity_f(par_data);
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (xfer_s) begin
                    shreg_d = shifted_s;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_IDX) begin
`ifdef PISO_PARITY_EN
                        state_d = ST_PAR;
`else
                        if (load_s) begin
                            state_d = ST_SHIFT;
                            shreg_d = par_data;
                            cnt_d   = {CNT_W{1'b0}};
                        end else begin
                            state_d = ST_IDLE;
                        end
`endif
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end else begin
                    state_d = ST_SHIFT;
                end
            end
`ifdef PISO_PARITY_EN
            ST_PAR: begin
                if (xfer_s) begin
                    if (load_s) begin
                        state_d = ST_SHIFT;
                        shreg_d = par_data;
                        cnt_d   = {CNT_W{1'b0}};
                        par_d   = parity_f(par_data);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_PAR;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                shreg_d = {DATA_W{1'b0}};
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State registers; reset discards any in-flight frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shreg_q <= {DATA_W{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
`ifdef PISO_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
`ifdef PISO_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: three instances (4-bit MSB, 4-bit LSB, 8-bit MSB).
module tb_piso_serializer;

    localparam bit PODD = 1'b0;
`ifdef PISO_PARITY_EN
    localparam int PX = 1;
`else
    localparam int PX = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [3:0] a_pd; logic a_pv, a_pr, a_sd, a_sv, a_srdy, a_sl, a_busy;
    logic [3:0] b_pd; logic b_pv, b_pr, b_sd, b_sv, b_srdy, b_sl, b_busy;
    logic [7:0] c_pd; logic c_pv, c_pr, c_sd, c_sv, c_srdy, c_sl, c_busy;

    piso_serializer #(.DATA_W(4), .MSB_FIRST(1'b1), .PARITY_ODD(PODD)) u_a (
        .clk(clk), .rst(rst), .par_data(a_pd), .par_valid(a_pv), .par_ready(a_pr),
        .ser_data(a_sd), .ser_valid(a_sv), .ser_ready(a_srdy), .ser_last(a_sl), .busy(a_busy));
    piso_serializer #(.DATA_W(4), .MSB_FIRST(1'b0), .PARITY_ODD(PODD)) u_b (
        .clk(clk), .rst(rst), .par_data(b_pd), .par_valid(b_pv), .par_ready(b_pr),
        .ser_data(b_sd), .ser_valid(b_sv), .ser_ready(b_srdy), .ser_last(b_sl), .busy(b_busy));
    piso_serializer #(.DATA_W(8), .MSB_FIRST(1'b1), .PARITY_ODD(PODD)) u_c (
        .clk(clk), .rst(rst), .par_data(c_pd), .par_valid(c_pv), .par_ready(c_pr),
        .ser_data(c_sd), .ser_valid(c_sv), .ser_ready(c_srdy), .ser_last(c_sl), .busy(c_busy));

    int n_cmp = 0;
    int n_err = 0;
    logic [1:0] qa[$], qb[$], qc[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // {bit, last} of beat i of a frame carrying word w
    function automatic logic [1:0] exp_beat(input logic [63:0] w, input int width,
                                            input bit msb, input int i);
        logic b, l;
        logic [63:0] m;
        if (i < width) begin
            b = msb ? w[width-1-i] : w[i];
            l = (PX == 0) && (i == width - 1);
        end else begin
            m = w & ((64'd1 << width) - 64'd1);
            b = (^m) ^ PODD;
            l = 1'b1;
        end
        return {b, l};
    endfunction

    // Monitors: pop and compare on every accepted serial beat
    always @(negedge clk) begin : mon_a
        logic [1:0] e;
        if (!rst && a_sv && a_srdy) begin
            if (qa.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL a_extra: got beat %b%b expected none", a_sd, a_sl);
            end else begin
                e = qa.pop_front();
                chk("a_beat", {a_sd, a_sl}, e);
            end
        end
    end
    always @(negedge clk) begin : mon_b
        logic [1:0] e;
        if (!rst && b_sv && b_srdy) begin
            if (qb.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL b_extra: got beat %b%b expected none", b_sd, b_sl);
            end else begin
                e = qb.pop_front();
                chk("b_beat", {b_sd, b_sl}, e);
            end
        end
    end
    always @(negedge clk) begin : mon_c
        logic [1:0] e;
        if (!rst && c_sv && c_srdy) begin
            if (qc.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL c_extra: got beat %b%b expected none", c_sd, c_sl);
            end else begin
                e = qc.pop_front();
                chk("c_beat", {c_sd, c_sl}, e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k;
        logic acc;
        rst = 1'b1;
        a_pd = 4'd0; a_pv = 1'b0; a_srdy = 1'b1;
        b_pd = 4'd0; b_pv = 1'b0; b_srdy = 1'b1;
        c_pd = 8'd0; c_pv = 1'b0; c_srdy = 1'b1;
        repeat (3) tick();
        chk("rst_valid", {a_sv, b_sv, c_sv}, 3'b000);
        chk("rst_busy", {a_busy, b_busy, c_busy}, 3'b000);
        chk("rst_last", {a_sl, b_sl, c_sl}, 3'b000);
        chk("rst_data", {a_sd, b_sd, c_sd}, 3'b000);
        rst = 1'b0;
        tick();
        chk("idle_ready", {a_pr, b_pr, c_pr}, 3'b111);

        // Test 1: 4-bit MSB-first, 1010
        a_pd = 4'b1010; a_pv = 1'b1;
        for (int i = 0; i < 4 + PX; i++) qa.push_back(exp_beat(64'hA, 4, 1'b1, i));
        tick();
        a_pv = 1'b0;
        chk("t1_busy_on", a_busy, 1'b1);
        for (k = 0; k < 20 && a_busy; k++) tick();
        chk("t1_busy_off", a_busy, 1'b0);
        chk("t1_drain", qa.size(), 0);

        // Test 2: 4-bit LSB-first, 1101 then 0011 held valid, no gap
        b_pd = 4'b1101; b_pv = 1'b1;
        for (int i = 0; i < 4 + PX; i++) qb.push_back(exp_beat(64'hD, 4, 1'b0, i));
        for (int i = 0; i < 4 + PX; i++) qb.push_back(exp_beat(64'h3, 4, 1'b0, i));
        tick();
        b_pd = 4'b0011;
        for (k = 0; k < 20; k++) begin
            acc = b_pr;
            tick();
            if (acc) break;
        end
        b_pv = 1'b0;
        chk("t2_ready_cycle", k, 3 + PX);
        chk("t2_nogap", b_sv, 1'b1);
        for (k = 0; k < 20 && b_busy; k++) tick();
        chk("t2_busy_off", b_busy, 1'b0);
        chk("t2_drain", qb.size(), 0);

        // Test 3: 8-bit A5 with a 3-cycle stall after two bits
        c_pd = 8'hA5; c_pv = 1'b1;
        for (int i = 0; i < 8 + PX; i++) qc.push_back(exp_beat(64'hA5, 8, 1'b1, i));
        tick();
        c_pv = 1'b0;
        repeat (2) tick();
        c_srdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_hold_data", c_sd, 1'b1);
            chk("t3_hold_last", c_sl, 1'b0);
            chk("t3_hold_valid", c_sv, 1'b1);
        end
        c_srdy = 1'b1;
        for (k = 0; k < 30 && c_busy; k++) tick();
        chk("t3_busy_off", c_busy, 1'b0);
        chk("t3_drain", qc.size(), 0);

        // Test 4: reset mid-frame, then a fresh word
        c_pd = 8'hFF; c_pv = 1'b1;
        for (int i = 0; i < 8 + PX; i++) qc.push_back(exp_beat(64'hFF, 8, 1'b1, i));
        tick();
        c_pv = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        #1;
        chk("t4_async_valid", c_sv, 1'b0);
        chk("t4_async_busy", c_busy, 1'b0);
        qc.delete();
        tick();
        rst = 1'b0;
        tick();
        c_pd = 8'h0F; c_pv = 1'b1;
        for (int i = 0; i < 8 + PX; i++) qc.push_back(exp_beat(64'h0F, 8, 1'b1, i));
        tick();
        c_pv = 1'b0;
        for (k = 0; k < 30 && c_busy; k++) tick();
        chk("t4_busy_off", c_busy, 1'b0);
        chk("t4_drain", qc.size(), 0);

        // Test 5: 0111 (parity 1 when the parity bit is built in)
        a_pd = 4'b0111; a_pv = 1'b1;
        for (int i = 0; i < 4 + PX; i++) qa.push_back(exp_beat(64'h7, 4, 1'b1, i));
        tick();
        a_pv = 1'b0;
        for (k = 0; k < 20 && a_busy; k++) tick();
        chk("t5_busy_off", a_busy, 1'b0);
        chk("t5_drain", qa.size(), 0);

        // Test 6: 1111 held valid while busy is captured exactly once
        a_pd = 4'b0110; a_pv = 1'b1;
        for (int i = 0; i < 4 + PX; i++) qa.push_back(exp_beat(64'h6, 4, 1'b1, i));
        for (int i = 0; i < 4 + PX; i++) qa.push_back(exp_beat(64'hF, 4, 1'b1, i));
        tick();
        a_pd = 4'b1111;
        for (k = 0; k < 20; k++) begin
            acc = a_pr;
            tick();
            if (acc) break;
        end
        a_pv = 1'b0;
        chk("t6_ready_cycle", k, 3 + PX);
        for (k = 0; k < 20 && a_busy; k++) tick();
        chk("t6_busy_off", a_busy, 1'b0);
        repeat (3) tick();
        chk("t6_drain", qa.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
